// File: rtl/costas_pi_lf.sv
// Proportional-integral loop filter for the Costas carrier-recovery loop.
// Three registered stages turn a phase-error stream into a saturated NCO frequency word around F0.
module costas_pi_lf #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int ACC_W = 32,
  parameter int F0    = 10000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    err_valid,
  input  logic signed [IN_W-1:0]  err,
  input  logic        [4:0]       kp_shift,
  input  logic        [4:0]       ki_shift,
  input  logic                    hold,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] freq,
  output logic                    freq_valid,
  output logic                    int_sat
);

  localparam int FRAC = ACC_W - OUT_W;
  localparam int SUM_W = ACC_W + 2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] F0_W    = OUT_W'(F0);
  localparam logic signed [SUM_W-1:0] F0_SH   = SUM_W'(F0_W) <<< FRAC;

  // Stage 1: align the error to the integrator's fixed point and apply the shift gains.
  logic signed [ACC_W-1:0] e_ext;
  logic signed [ACC_W-1:0] e_al;
  logic signed [ACC_W-1:0] p1;
  logic signed [ACC_W-1:0] inc1;
  logic                    v1;

  always_comb begin
    e_ext = ACC_W'(err);
    e_al  = e_ext <<< FRAC;
  end

  // NOTE: sequential state is always written with non-blocking assignments so every
  // stage samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1   <= '0;
      inc1 <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= err_valid;
      if (err_valid) begin
        p1   <= e_al >>> kp_shift;
        inc1 <= e_al >>> ki_shift;
      end
    end
  end

  // Stage 2: saturating integrator with clear (highest priority) and hold.
  logic signed [ACC_W-1:0] integ;
  logic signed [ACC_W-1:0] p2;
  logic                    v2;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] integ_upd;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    acc_sum   = {integ[ACC_W-1], integ} + {inc1[ACC_W-1], inc1};
    integ_upd = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      integ_upd = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      integ   <= '0;
      int_sat <= 1'b0;
      p2      <= '0;
      v2      <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p2 <= p1;
      end
      if (clr) begin
        integ   <= '0;
        int_sat <= 1'b0;
      end else if (v1 && !hold) begin
        integ   <= integ_upd;
        int_sat <= (integ_upd == ACC_MAX) || (integ_upd == ACC_MIN);
      end
    end
  end

  // Stage 3: centre on F0, drop the fractional bits (floor) and clamp to the output range.
  logic signed [SUM_W-1:0] s_full;
  logic signed [SUM_W-1:0] s_int;
  logic                    s_fits;
  logic signed [OUT_W-1:0] freq_d;

  always_comb begin
    s_full = F0_SH + SUM_W'(integ) + SUM_W'(p2);
    s_int  = s_full >>> FRAC;
    s_fits = (&s_int[SUM_W-1:OUT_W-1]) || !(|s_int[SUM_W-1:OUT_W-1]);
    freq_d = s_int[OUT_W-1:0];
    if (!s_fits) begin
      freq_d = s_int[SUM_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq       <= F0_W;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= v2;
      if (v2) begin
        freq <= freq_d;
      end
    end
  end

endmodule

// File: tb/tb_costas_pi_lf.sv
// Directed self-checking bench for costas_pi_lf: latency, integration, saturation,
// hold/clear, gain changes and reset behaviour against hand-computed frequency words.
module tb_costas_pi_lf;

  logic               clk;
  logic               reset;
  logic               err_valid;
  logic signed [15:0] err;
  logic        [4:0]  kp_shift;
  logic        [4:0]  ki_shift;
  logic               hold;
  logic               clr;
  logic signed [15:0] freq;
  logic               freq_valid;
  logic               int_sat;

  int tests_run    = 0;
  int tests_failed = 0;
  int fq[$];

  costas_pi_lf #(
    .IN_W (16),
    .OUT_W(16),
    .ACC_W(32),
    .F0   (10000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .err_valid (err_valid),
    .err       (err),
    .kp_shift  (kp_shift),
    .ki_shift  (ki_shift),
    .hold      (hold),
    .clr       (clr),
    .freq      (freq),
    .freq_valid(freq_valid),
    .int_sat   (int_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every strobed frequency word.
  always @(posedge clk) begin
    #1;
    if (freq_valid === 1'b1) fq.push_back(int'(freq));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int e, input int kp, input int ki);
    err_valid = 1'b1;
    err       = e[15:0];
    kp_shift  = kp[4:0];
    ki_shift  = ki[4:0];
    step();
    err_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    err_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_integ();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run++;
    if (freq !== 16'sd10000 || freq_valid !== 1'b0 || int_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: freq=%0d valid=%b sat=%b, required 10000/0/0", freq, freq_valid, int_sat);
    end
    reset = 1'b1;
    step();
    send(256, 4, 8);
    send(256, 4, 8);
    send(256, 4, 8);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (freq !== 16'sd10000 || freq_valid !== 1'b0 || int_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: freq=%0d valid=%b sat=%b, required 10000/0/0", freq, freq_valid, int_sat);
    end
    fq.delete();
    step();
    reset = 1'b1;
    drain(5);
    tests_run++;
    if (fq.size() != 0 || freq !== 16'sd10000) begin
      tests_failed++;
      $display("FAIL reset_flush: strobes=%0d freq=%0d, required 0 strobes and 10000", fq.size(), freq);
    end
  endtask

  task automatic test_impulse();
    fq.delete();
    send(256, 4, 8);
    tests_run++;
    if (freq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL impulse_lat1: valid=%b, required 0", freq_valid);
    end
    step();
    tests_run++;
    if (freq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL impulse_lat2: valid=%b, required 0", freq_valid);
    end
    step();
    tests_run++;
    if (freq_valid !== 1'b1 || freq !== 16'sd10017) begin
      tests_failed++;
      $display("FAIL impulse_out: valid=%b freq=%0d, required 1/10017", freq_valid, freq);
    end
    step();
    tests_run++;
    if (freq_valid !== 1'b0 || freq !== 16'sd10017) begin
      tests_failed++;
      $display("FAIL impulse_pulse: valid=%b freq=%0d, required 0/10017", freq_valid, freq);
    end
    send(0, 4, 8);
    drain(5);
    tests_run++;
    if (fq.size() != 2 || fq[fq.size()-1] != 10001) begin
      tests_failed++;
      $display("FAIL impulse_zero: strobes=%0d last=%0d, required 2 strobes, last 10001",
               fq.size(), (fq.size() > 0) ? fq[fq.size()-1] : 0);
    end
  endtask

  task automatic test_ramp();
    clear_integ();
    fq.delete();
    for (int i = 0; i < 10; i++) send(256, 31, 8);
    drain(5);
    tests_run++;
    if (fq.size() != 10) begin
      tests_failed++;
      $display("FAIL ramp_count: strobes=%0d, required 10", fq.size());
    end
    for (int i = 0; i < 10 && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] != 10001 + i) begin
        tests_failed++;
        $display("FAIL ramp_%0d: freq=%0d, required %0d", i, fq[i], 10001 + i);
      end
    end
    tests_run++;
    if (int_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_sat: int_sat=%b, required 0", int_sat);
    end
  endtask

  task automatic test_saturation();
    int e_tab[6]   = '{32767, 32767, 32767, -32768, -32768, -32768};
    int kp_tab[6]  = '{31, 31, 31, 0, 0, 0};
    int f_tab[6]   = '{32767, 32767, 32767, -22769, -32768, -32768};
    bit s_tab[6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_integ();
    for (int i = 0; i < 6; i++) begin
      fq.delete();
      send(e_tab[i], kp_tab[i], 0);
      drain(4);
      tests_run++;
      if (fq.size() != 1 || fq[0] != f_tab[i] || int_sat !== s_tab[i]) begin
        tests_failed++;
        $display("FAIL sat_%0d: strobes=%0d freq=%0d sat=%b, required 1/%0d/%b",
                 i, fq.size(), (fq.size() > 0) ? fq[0] : 0, int_sat, f_tab[i], s_tab[i]);
      end
    end
  endtask

  task automatic test_clear();
    fq.delete();
    clr = 1'b1;
    send(256, 4, 8);
    step();
    clr = 1'b0;
    drain(4);
    tests_run++;
    if (fq.size() != 1 || fq[0] != 10016 || int_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_sample: strobes=%0d freq=%0d sat=%b, required 1/10016/0",
               fq.size(), (fq.size() > 0) ? fq[0] : 0, int_sat);
    end
    fq.delete();
    send(0, 31, 8);
    drain(5);
    tests_run++;
    if (fq.size() != 1 || fq[0] != 10000) begin
      tests_failed++;
      $display("FAIL clear_integ: strobes=%0d freq=%0d, required 1/10000",
               fq.size(), (fq.size() > 0) ? fq[0] : 0);
    end
  endtask

  task automatic test_hold();
    clear_integ();
    fq.delete();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(256, 4, 8);
    drain(5);
    hold = 1'b0;
    send(0, 31, 8);
    drain(5);
    tests_run++;
    if (fq.size() != 4) begin
      tests_failed++;
      $display("FAIL hold_count: strobes=%0d, required 4", fq.size());
    end
    for (int i = 0; i < 4 && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] != ((i < 3) ? 10016 : 10000)) begin
        tests_failed++;
        $display("FAIL hold_%0d: freq=%0d, required %0d", i, fq[i], (i < 3) ? 10016 : 10000);
      end
    end
  endtask

  task automatic test_gain_change();
    int exp_f[6] = '{10002, 10003, 10005, 10006, 10008, 10009};
    clear_integ();
    fq.delete();
    for (int i = 0; i < 6; i++) send(512, 31, (i % 2 == 0) ? 8 : 9);
    drain(5);
    tests_run++;
    if (fq.size() != 6) begin
      tests_failed++;
      $display("FAIL gain_count: strobes=%0d, required 6", fq.size());
    end
    for (int i = 0; i < 6 && i < fq.size(); i++) begin
      tests_run++;
      if (fq[i] != exp_f[i]) begin
        tests_failed++;
        $display("FAIL gain_%0d: freq=%0d, required %0d", i, fq[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_boundary();
    clear_integ();
    fq.delete();
    send(1, 0, 31);
    send(-1, 31, 31);
    drain(5);
    tests_run++;
    if (fq.size() != 2 || fq[0] != 10001 || fq[1] != 9999 || int_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL boundary_shift: strobes=%0d f0=%0d f1=%0d sat=%b, required 2/10001/9999/0",
               fq.size(), (fq.size() > 0) ? fq[0] : 0, (fq.size() > 1) ? fq[1] : 0, int_sat);
    end
  endtask

  initial begin
    reset     = 1'b0;
    err_valid = 1'b0;
    err       = '0;
    kp_shift  = '0;
    ki_shift  = '0;
    hold      = 1'b0;
    clr       = 1'b0;
    test_reset();
    test_impulse();
    test_ramp();
    test_saturation();
    test_clear();
    test_hold();
    test_gain_change();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/costas_pi_lf.md
Name: costas_pi_lf

Overview:
- Parametrised proportional-integral loop filter for the Costas carrier-recovery loop.
- Sits between the I·Q phase detector and the carrier NCO.
- Converts a signed phase-error sample stream into a saturated signed NCO frequency word centred on a programmable rest frequency.
- Adds features the fixed-gain integrator lacked:
  - runtime shift-based Kp/Ki gains
  - valid handshake
  - integrator hold and clear
  - saturation with status flag
  - registered 3-stage pipeline

Parameters:
- IN_W, 16, phase-error width (signed).
- OUT_W, 16, NCO frequency word width (signed).
- ACC_W, 32, integrator width. FRAC = ACC_W-OUT_W fractional bits. ACC_W > OUT_W and ACC_W ≥ IN_W+FRAC.
- F0, 10000, rest (centre) frequency word, OUT_W-bit signed integer.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- err_valid  in  1  err is a new sample this cycle.
- err  in  IN_W  signed phase error.
- kp_shift  in  5  proportional gain exponent; Kp = 2^-kp_shift. Sampled with err.
- ki_shift  in  5  integral gain exponent; Ki = 2^-ki_shift. Sampled with err.
- hold  in  1  freeze integrator; proportional path stays active.
- clr  in  1  synchronous integrator clear.
- freq  out  OUT_W  signed NCO frequency word.
- freq_valid  out  1  one-cycle strobe: freq updated.
- int_sat  out  1  integrator is at a saturation limit.

Behaviour:
- Reset (reset=0, asynchronous):
  - all pipeline registers and integrator = 0
  - freq = F0, freq_valid = 0, int_sat = 0
  - in-flight samples are discarded.
- Stage 1, on a cycle with err_valid=1:
  - e = sign-extend(err) to ACC_W, then << FRAC.
  - Register p = e >>> kp_shift and inc = e >>> ki_shift (arithmetic shifts, floor).
  - Register v1 = 1.
- Stage 2, when v1=1:
  - If clr=1: integ <= 0. clr has priority over hold and update.
  - Else if hold=1: integ unchanged.
  - Else: integ <= sat_ACC(integ + inc), with limits [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Register p2 = p and v2 = 1.
- clr and hold are also honoured on cycles with v1=0: clr zeroes integ, hold is a no-op.
- int_sat is registered: 1 when the value written to integ equals either limit, otherwise 0. clr forces it to 0.
- Stage 3, when v2=1:
  - s = (F0 << FRAC) + integ + p2, computed in ACC_W+2 bits so no intermediate overflow.
  - freq <= sat_OUT(s >>> FRAC), with limits [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - freq_valid <= 1 for one cycle; otherwise freq_valid <= 0 and freq holds.
- Latency:
  - err_valid at edge n gives freq_valid high after edge n+3.
  - freq includes the same sample's integral increment.
  - Back-to-back samples are accepted every cycle; throughput is one sample per clock.
  - There is no backpressure.
- Boundary rules:
  - kp_shift=0 / ki_shift=0 is a unit gain.
  - Shifts ≥ ACC_W-1 reduce the term to 0 (positive err) or -1 LSB (negative err).
  - err_valid=0 cycles leave integ unchanged.
  - Changing kp_shift/ki_shift mid-stream affects only samples accepted from that cycle onward.
  - Reset deassertion needs no special sequencing: the first sample after release follows normal latency.

Test Plan:
- Reset: assert reset=0 mid-operation → freq=10000 immediately, freq_valid=0, int_sat=0, and no strobe for samples in flight.
- Single impulse: err=256, kp_shift=4, ki_shift=8, one valid cycle → 3 cycles later freq=10017 and freq_valid pulses once. A following err=0 sample gives freq=10001.
- Integration ramp: err=256 on 10 consecutive cycles, kp_shift=31, ki_shift=8 → freq strobes each cycle at 10001, 10002, …, 10010 and int_sat stays 0.
- Saturation:
  - err=32767, ki_shift=0, kp_shift=31, repeated → second sample saturates integ at 0x7FFFFFFF, int_sat=1, freq=32767.
  - err=-32768, repeated → integ=0x80000000, freq=-32768.
- Hold/clear:
  - hold=1 with err=256, kp=4, ki=8 → freq=10016 every sample and integ is unchanged.
  - clr=1 coincident with a valid sample → integ=0, int_sat=0, freq=F0+p.
- Gain change mid-stream: alternate ki_shift between 8 and 9 per sample with err=512 → integral steps alternate between +2 and +1 output LSB with no sample lost.
